// File: rtl/if_window_reader.sv
// if_window_reader: walks sliding 1-D windows over the circular IF scratchpad.
// Define IF_WINDOW_OVERRUN_CHK_EN to enable the sticky writer-lap detector.
module if_window_reader #(
    parameter int SCRATCH_WIDTH        = 8,
    parameter int SCRATCH_ADDRESS_SIZE = 8,
    parameter int FILT_WIDTH           = 4,
    parameter int WIN_CNT_WIDTH        = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [SCRATCH_ADDRESS_SIZE-1:0] base_addr,
    input  logic [FILT_WIDTH-1:0]           filt_size,
    input  logic [FILT_WIDTH-1:0]           stride,
    input  logic [WIN_CNT_WIDTH-1:0]        num_windows,
    input  logic [SCRATCH_ADDRESS_SIZE-1:0] last_write,
    input  logic [SCRATCH_WIDTH-1:0]        scratch_dout,
    output logic [SCRATCH_ADDRESS_SIZE-1:0] read_addr,
    output logic [SCRATCH_WIDTH-1:0]        dout,
    output logic                            dout_valid,
    input  logic                            out_ready,
    output logic                            window_last,
    output logic                            busy,
    output logic                            done,
    output logic                            overrun_err
);

    localparam int AW = SCRATCH_ADDRESS_SIZE;
    localparam int FW = FILT_WIDTH;
    localparam int WW = WIN_CNT_WIDTH;
    localparam int CW = AW + FW;

    localparam logic [AW-1:0] A_ONE = AW'(1);
    localparam logic [FW-1:0] F_ONE = FW'(1);
    localparam logic [WW-1:0] W_ONE = WW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [AW-1:0] win_base;
    logic [AW-1:0] addr_q;
    logic [FW-1:0] offset;
    logic [FW-1:0] filt_q;
    logic [FW-1:0] stride_q;
    logic [WW-1:0] win_cnt;
    logic [WW-1:0] nwin_q;
    logic          pres_q;

    logic [AW-1:0] avail;
    logic          data_ok;
    logic          rd_valid;
    logic          fire;
    logic          last_off;
    logic          last_win;

    // Zero-extend both sides so any FILT_WIDTH/address width mix compares correctly.
    assign avail    = last_write - win_base;
    assign data_ok  = CW'(avail) >= CW'(filt_q);
    assign rd_valid = (state == S_READ) && pres_q;
    assign fire     = rd_valid && out_ready;
    assign last_off = (offset == (filt_q - F_ONE));
    assign last_win = (win_cnt == (nwin_q - W_ONE));
    assign dout     = scratch_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (num_windows == '0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (data_ok) begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                if (fire && last_off) begin
                    state_nxt = last_win ? S_DONE : S_WAIT;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        dout_valid  = rd_valid;
        window_last = rd_valid && last_off;
        busy        = (state != S_IDLE);
        done        = (state == S_DONE);
        read_addr   = addr_q;
        // Look-ahead on a fire so the registered scratchpad output streams.
        if (state == S_READ && fire) begin
            read_addr = addr_q + A_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_base <= '0;
            addr_q   <= '0;
            offset   <= '0;
            filt_q   <= '0;
            stride_q <= '0;
            win_cnt  <= '0;
            nwin_q   <= '0;
            pres_q   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        win_base <= base_addr;
                        filt_q   <= (filt_size == '0) ? F_ONE : filt_size;
                        stride_q <= stride;
                        nwin_q   <= num_windows;
                        win_cnt  <= '0;
                    end
                end
                S_WAIT: begin
                    addr_q <= win_base;
                    offset <= '0;
                    pres_q <= 1'b0;
                end
                S_READ: begin
                    pres_q <= !(fire && last_off);
                    if (fire) begin
                        addr_q <= addr_q + A_ONE;
                        offset <= offset + F_ONE;
                        if (last_off) begin
                            win_base <= win_base + AW'(stride_q);
                            win_cnt  <= win_cnt + W_ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef IF_WINDOW_OVERRUN_CHK_EN
    logic overrun_q;

    // The writer has lapped the live window once avail shrinks during READ.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (state == S_READ && !data_ok) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun_err = overrun_q;
`else
    assign overrun_err = 1'b0;
`endif

endmodule

// File: tb/tb_if_window_reader.sv
// Self-checking bench for if_window_reader: vector table plus scoreboard queue.
// Overrun expectation follows IF_WINDOW_OVERRUN_CHK_EN.
module tb_if_window_reader;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int FW = 4;
    localparam int WW = 8;

`ifdef IF_WINDOW_OVERRUN_CHK_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [FW-1:0] filt_size;
    logic [FW-1:0] stride;
    logic [WW-1:0] num_windows;
    logic [AW-1:0] last_write;
    logic [DW-1:0] scratch_dout = '0;
    logic [AW-1:0] read_addr;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          out_ready;
    logic          window_last;
    logic          busy;
    logic          done;
    logic          overrun_err;

    int total = 0;
    int bad   = 0;
    int since = 0;

    typedef struct {
        logic [AW-1:0] base;
        logic [FW-1:0] filt;
        logic [FW-1:0] stride;
        logic [WW-1:0] nwin;
        logic [AW-1:0] lw;
        int            mode;
        int            beats;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t q[$];
    vec_t vecs[8];

    if_window_reader #(
        .SCRATCH_WIDTH(DW),
        .SCRATCH_ADDRESS_SIZE(AW),
        .FILT_WIDTH(FW),
        .WIN_CNT_WIDTH(WW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .base_addr(base_addr),
        .filt_size(filt_size),
        .stride(stride),
        .num_windows(num_windows),
        .last_write(last_write),
        .scratch_dout(scratch_dout),
        .read_addr(read_addr),
        .dout(dout),
        .dout_valid(dout_valid),
        .out_ready(out_ready),
        .window_last(window_last),
        .busy(busy),
        .done(done),
        .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    // Bijective content so a wrong address always shows up as wrong data.
    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return (a * 8'd7) ^ 8'h3C;
    endfunction

    always @(posedge clk) scratch_dout <= pat(read_addr);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic launch(input vec_t v);
        int fe;
        logic [AW-1:0] a;
        base_addr   = v.base;
        filt_size   = v.filt;
        stride      = v.stride;
        num_windows = v.nwin;
        last_write  = v.lw;
        start       = 1'b1;
        fe = (v.filt == '0) ? 1 : int'(v.filt);
        for (int w = 0; w < int'(v.nwin); w++) begin
            for (int k = 0; k < fe; k++) begin
                a = AW'(int'(v.base) + w * int'(v.stride) + k);
                q.push_back('{pat(a), (k == fe - 1)});
            end
        end
        @(posedge clk);
        #1;
        start       = 1'b0;
        since       = 0;
        base_addr   = ~v.base;
        filt_size   = ~v.filt;
        stride      = ~v.stride;
        num_windows = ~v.nwin;
    endtask

    task automatic drain(input int mode, input int beats_exp);
        bit got;
        bit pst;
        int nb;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        exp_t e;
        got = 0;
        pst = 0;
        nb  = 0;
        pa  = '0;
        pd  = '0;
        for (int c = 0; c < 400 && !got; c++) begin
            case (mode)
                1: out_ready = ($urandom_range(0, 2) != 0);
                2: out_ready = !(c >= 4 && c < 8);
                default: out_ready = 1'b1;
            endcase
            @(negedge clk);
            since++;
            if (pst) begin
                chk("stall_dout", dout, pd);
                chk("stall_valid", dout_valid, 1);
                if (!out_ready) chk("stall_addr", read_addr, pa);
            end
            pst = dout_valid && !out_ready;
            pa  = read_addr;
            pd  = dout;
            if (done) begin
                chk("done_gap", since, 1);
                chk("done_q_empty", q.size(), 0);
                got = 1;
            end
            if (dout_valid && out_ready) begin
                since = 0;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat: got data %0h want none", dout);
                end else begin
                    e = q.pop_front();
                    nb++;
                    chk("beat_data", dout, e.data);
                    chk("beat_last", window_last, e.last);
                end
            end
            @(posedge clk);
            #1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got no done want done, %0d left", q.size());
            q.delete();
        end
        chk("beat_count", nb, beats_exp);
        out_ready = 1'b1;
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("idle_after", busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got hang want finish");
        $fatal(1);
    end

    initial begin
        vec_t g;
        vecs[0] = '{8'd0,   4'd3,  4'd1, 8'd2, 8'd8,   0, 6};
        vecs[1] = '{8'd254, 4'd4,  4'd1, 8'd1, 8'd3,   0, 4};
        vecs[2] = '{8'd20,  4'd0,  4'd1, 8'd3, 8'd30,  0, 3};
        vecs[3] = '{8'd0,   4'd5,  4'd1, 8'd0, 8'd0,   0, 0};
        vecs[4] = '{8'd5,   4'd2,  4'd0, 8'd2, 8'd10,  0, 4};
        vecs[5] = '{8'd10,  4'd6,  4'd2, 8'd2, 8'd100, 2, 12};
        vecs[6] = '{8'd100, 4'd5,  4'd3, 8'd3, 8'd120, 1, 15};
        vecs[7] = '{8'd250, 4'd15, 4'd7, 8'd2, 8'd30,  1, 30};

        rst         = 1'b1;
        start       = 1'b0;
        base_addr   = '0;
        filt_size   = '0;
        stride      = '0;
        num_windows = '0;
        last_write  = '0;
        out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start       = 1'b1;
        num_windows = 8'd1;
        filt_size   = 4'd1;
        last_write  = 8'd8;
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        chk("rst_valid", dout_valid, 0);
        chk("rst_last", window_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovr", overrun_err, 0);
        chk("rst_addr", read_addr, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            launch(vecs[i]);
            drain(vecs[i].mode, vecs[i].beats);
        end

        g = '{8'd0, 4'd3, 4'd1, 8'd1, 8'd2, 0, 3};
        launch(g);
        out_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("gate_hold", dout_valid, 0);
            chk("gate_busy", busy, 1);
            @(posedge clk);
            #1;
        end
        last_write = 8'd3;
        @(negedge clk);
        chk("gate_t1", dout_valid, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("gate_t2", dout_valid, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("gate_valid", dout_valid, 1);
        chk("gate_data", dout, pat(8'd0));
        @(posedge clk);
        #1;
        drain(0, 3);

        g = '{8'd40, 4'd8, 4'd1, 8'd2, 8'd60, 0, 0};
        launch(g);
        out_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("mid_valid", dout_valid, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        chk("abort_valid", dout_valid, 0);
        chk("abort_last", window_last, 0);
        chk("abort_busy", busy, 0);
        chk("abort_addr", read_addr, 0);
        repeat (5) begin
            chk("abort_no_done", done, 0);
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        @(posedge clk);
        #1;

        g = '{8'd0, 4'd8, 4'd1, 8'd1, 8'd8, 0, 8};
        launch(g);
        out_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        chk("ovr_before", overrun_err, 0);
        last_write = 8'd2;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("ovr_set", overrun_err, OVR_EXP);
        @(posedge clk);
        #1;
        drain(0, 8);
        chk("ovr_sticky", overrun_err, OVR_EXP);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ovr_clear", overrun_err, 0);
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
